// File: rtl/pid_seq.sv
// Sequential fixed-point PID controller: one shared signed multiplier serves the P, I and D terms.
// Define PID_ANTIWINDUP_EN to freeze the integrator while the previous result is clamped.
module pid_seq #(
    parameter int unsigned          W       = 18,
    parameter int unsigned          FRAC    = 8,
    parameter logic signed [W-1:0]  OUT_MAX = {1'b0, {(W-1){1'b1}}},
    parameter logic signed [W-1:0]  OUT_MIN = {1'b1, {(W-1){1'b0}}}
) (
    input  logic                sclk,
    input  logic                rst,
    input  logic                enable,
    input  logic                clear,
    input  logic signed [W-1:0] yk,
    input  logic signed [W-1:0] rk,
    input  logic signed [W-1:0] kp,
    input  logic signed [W-1:0] ki,
    input  logic signed [W-1:0] kd,
    output logic signed [W-1:0] pid_output,
    output logic                busy,
    output logic                done
);

`ifdef PID_ANTIWINDUP_EN
    localparam bit AntiWindup = 1'b1;
`else
    localparam bit AntiWindup = 1'b0;
`endif

    localparam int unsigned AW = 2 * W + 2;

    typedef enum logic [2:0] {StIdle, StErr, StMulP, StMulI, StMulD, StSum} state_e;

    state_e state_q, state_d;

    logic signed [W-1:0]  y_q, r_q, kp_q, ki_q, kd_q;
    logic signed [W-1:0]  e_q, d_q, integ_q, e_prev_q;
    logic signed [AW-1:0] acc_q;
    logic signed [W-1:0]  out_q;
    logic                 done_q, sat_hi_q, sat_lo_q;

    logic signed [W-1:0]   mul_a, mul_b;
    logic signed [2*W-1:0] prod, term;
    logic signed [AW-1:0]  term_ext, max_ext, min_ext;
    logic signed [W:0]     e_wide, integ_wide, d_wide;
    logic signed [W-1:0]   e_new;
    logic                  hold;

    function automatic logic signed [W-1:0] sat_w(input logic signed [W:0] x);
        if (x[W] == x[W-1]) return x[W-1:0];
        else if (x[W])      return {1'b1, {(W-1){1'b0}}};
        else                return {1'b0, {(W-1){1'b1}}};
    endfunction

    always_ff @(posedge sclk) begin
        if (rst) state_q <= StIdle;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (enable) state_d = StErr;
            StErr:   state_d = StMulP;
            StMulP:  state_d = StMulI;
            StMulI:  state_d = StMulD;
            StMulD:  state_d = StSum;
            StSum:   state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        busy  = (state_q != StIdle);
        mul_a = kp_q;
        mul_b = e_q;
        unique case (state_q)
            StMulI: begin
                mul_a = ki_q;
                mul_b = integ_q;
            end
            StMulD: begin
                mul_a = kd_q;
                mul_b = d_q;
            end
            default: ;
        endcase
    end

    always_comb begin
        e_wide     = {r_q[W-1], r_q} - {y_q[W-1], y_q};
        e_new      = sat_w(e_wide);
        integ_wide = {integ_q[W-1], integ_q} + {e_new[W-1], e_new};
        d_wide     = {e_new[W-1], e_new} - {e_prev_q[W-1], e_prev_q};
        // Saturation flags are those of the previous result.
        hold       = AntiWindup && ((sat_hi_q && !e_new[W-1] && (e_new != '0)) ||
                                    (sat_lo_q && e_new[W-1]));
        prod       = $signed({{W{mul_a[W-1]}}, mul_a}) * $signed({{W{mul_b[W-1]}}, mul_b});
        term       = prod >>> FRAC;
        term_ext   = {{2{term[2*W-1]}}, term};
        max_ext    = {{(W+2){OUT_MAX[W-1]}}, OUT_MAX};
        min_ext    = {{(W+2){OUT_MIN[W-1]}}, OUT_MIN};
    end

    always_ff @(posedge sclk) begin
        if (rst) begin
            y_q      <= '0;
            r_q      <= '0;
            kp_q     <= '0;
            ki_q     <= '0;
            kd_q     <= '0;
            e_q      <= '0;
            d_q      <= '0;
            integ_q  <= '0;
            e_prev_q <= '0;
            acc_q    <= '0;
            out_q    <= '0;
            done_q   <= 1'b0;
            sat_hi_q <= 1'b0;
            sat_lo_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (clear) begin
                        integ_q  <= '0;
                        e_prev_q <= '0;
                    end
                    if (enable) begin
                        y_q  <= yk;
                        r_q  <= rk;
                        kp_q <= kp;
                        ki_q <= ki;
                        kd_q <= kd;
                    end
                end
                StErr: begin
                    e_q      <= e_new;
                    d_q      <= sat_w(d_wide);
                    e_prev_q <= e_new;
                    if (!hold) integ_q <= sat_w(integ_wide);
                end
                StMulP: acc_q <= term_ext;
                StMulI: acc_q <= acc_q + term_ext;
                StMulD: acc_q <= acc_q + term_ext;
                StSum: begin
                    if (acc_q > max_ext)      out_q <= OUT_MAX;
                    else if (acc_q < min_ext) out_q <= OUT_MIN;
                    else                      out_q <= acc_q[W-1:0];
                    sat_hi_q <= (acc_q > max_ext);
                    sat_lo_q <= (acc_q < min_ext);
                    done_q   <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign pid_output = out_q;
    assign done       = done_q;

endmodule

// File: tb/tb_pid_seq.sv
// Directed bench for pid_seq (W=18, FRAC=8, clamp +/-1000); honours PID_ANTIWINDUP_EN.
module tb_pid_seq;
    localparam int W = 18;

    logic                sclk = 1'b0;
    logic                rst, enable, clear;
    logic signed [W-1:0] yk, rk, kp, ki, kd;
    logic signed [W-1:0] pid_output;
    logic                busy, done;

    int checks = 0;
    int errors = 0;

    always #5 sclk = ~sclk;

    pid_seq #(
        .W       (W),
        .FRAC    (8),
        .OUT_MAX (18'sd1000),
        .OUT_MIN (-18'sd1000)
    ) dut (
        .sclk       (sclk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .yk         (yk),
        .rk         (rk),
        .kp         (kp),
        .ki         (ki),
        .kd         (kd),
        .pid_output (pid_output),
        .busy       (busy),
        .done       (done)
    );

    task automatic set_gains(input int p, input int i, input int d);
        @(negedge sclk);
        kp = 18'(p);
        ki = 18'(i);
        kd = 18'(d);
    endtask

    task automatic pulse_clear();
        @(negedge sclk);
        clear = 1'b1;
        @(posedge sclk);
        #1 clear = 1'b0;
    endtask

    // Returns cycles from the enable edge to done, or -1 if done never came.
    task automatic run_op(input int r, input int y, output int lat);
        @(negedge sclk);
        rk     = 18'(r);
        yk     = 18'(y);
        enable = 1'b1;
        @(posedge sclk);
        #1 enable = 1'b0;
        lat = -1;
        for (int n = 1; n <= 20; n++) begin
            @(posedge sclk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; enable = 1'b1; clear = 1'b0;
        rk = 18'sd1000; yk = '0; kp = 18'sd256; ki = '0; kd = '0;
        repeat (10) @(posedge sclk);
        #1;
        checks++;
        if (pid_output !== 18'sd0) begin
            errors++; $display("FAIL reset_out: got %0d want 0", pid_output);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        @(negedge sclk);
        rst = 1'b0; enable = 1'b0;
        repeat (3) @(posedge sclk);
        #1;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL reset_en_ignored: busy %b want 0", busy); end
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL reset_no_done: done %b want 0", done); end
    endtask

    task automatic test_reset_mid_op();
        int n_done = 0;
        set_gains(256, 0, 0);
        @(negedge sclk);
        rk = 18'sd600; yk = '0; enable = 1'b1;
        @(posedge sclk);
        #1 enable = 1'b0;
        @(posedge sclk);
        #1;
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL midop_busy: got %b want 1", busy); end
        @(negedge sclk);
        rst = 1'b1;
        @(posedge sclk);
        #1 rst = 1'b0;
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL midop_abort: busy %b want 0", busy); end
        for (int n = 0; n < 8; n++) begin
            @(posedge sclk);
            #1 if (done) n_done++;
        end
        checks++;
        if (n_done !== 0) begin errors++; $display("FAIL midop_done: %0d pulses want 0", n_done); end
        checks++;
        if (pid_output !== 18'sd0) begin
            errors++; $display("FAIL midop_out: got %0d want 0", pid_output);
        end
    endtask

    task automatic test_p_only();
        int lat;
        set_gains(256, 0, 0);
        run_op(1000, 400, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL p_latency: got %0d want 5", lat); end
        checks++;
        if (pid_output !== 18'sd600) begin
            errors++; $display("FAIL p_pos: got %0d want 600", pid_output);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL p_busy_at_done: got %b want 0", busy); end
        run_op(0, 300, lat);
        checks++;
        if (pid_output !== -18'sd300) begin
            errors++; $display("FAIL p_neg: got %0d want -300", pid_output);
        end
    endtask

    task automatic test_i_only();
        int lat;
        pulse_clear();
        set_gains(0, 128, 0);
        for (int k = 1; k <= 3; k++) begin
            run_op(100, 0, lat);
            checks++;
            if (pid_output !== 18'(50 * k)) begin
                errors++; $display("FAIL i_op%0d: got %0d want %0d", k, pid_output, 50 * k);
            end
        end
        pulse_clear();
        run_op(100, 0, lat);
        checks++;
        if (pid_output !== 18'sd50) begin
            errors++; $display("FAIL i_after_clear: got %0d want 50", pid_output);
        end
    endtask

    task automatic test_d_only();
        int lat;
        int n_done = 0;
        pulse_clear();
        set_gains(0, 0, 256);
        run_op(100, 0, lat);
        checks++;
        if (pid_output !== 18'sd100) begin
            errors++; $display("FAIL d_op1: got %0d want 100", pid_output);
        end
        run_op(300, 0, lat);
        checks++;
        if (pid_output !== 18'sd200) begin
            errors++; $display("FAIL d_op2: got %0d want 200", pid_output);
        end
        @(negedge sclk);
        rk = 18'sd300; yk = '0; enable = 1'b1;
        @(posedge sclk);
        #1 enable = 1'b0;
        @(negedge sclk);
        rk = 18'sd5000; enable = 1'b1;
        @(posedge sclk);
        #1 enable = 1'b0;
        for (int n = 0; n < 14; n++) begin
            @(posedge sclk);
            #1 if (done) n_done++;
        end
        checks++;
        if (n_done !== 1) begin errors++; $display("FAIL d_busy_enable: %0d dones want 1", n_done); end
        checks++;
        if (pid_output !== 18'sd0) begin
            errors++; $display("FAIL d_op3: got %0d want 0", pid_output);
        end
    endtask

    task automatic test_clamp();
        int lat;
        set_gains(512, 0, 0);
        run_op(800, 0, lat);
        checks++;
        if (pid_output !== 18'sd1000) begin
            errors++; $display("FAIL clamp_hi: got %0d want 1000", pid_output);
        end
        run_op(0, 800, lat);
        checks++;
        if (pid_output !== -18'sd1000) begin
            errors++; $display("FAIL clamp_lo: got %0d want -1000", pid_output);
        end
    endtask

    task automatic test_windup();
        int lat;
        int e_seq [4] = '{600, 600, 600, -300};
`ifdef PID_ANTIWINDUP_EN
        int exp_seq [4] = '{600, 1000, 1000, 900};
`else
        int exp_seq [4] = '{600, 1000, 1000, 1000};
`endif
        pulse_clear();
        set_gains(0, 256, 0);
        for (int k = 0; k < 4; k++) begin
            run_op(e_seq[k], 0, lat);
            checks++;
            if (pid_output !== 18'(exp_seq[k])) begin
                errors++;
                $display("FAIL windup_op%0d: got %0d want %0d", k, pid_output, exp_seq[k]);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        set_gains(256, 0, 0);
        run_op(10, 0, lat);
        run_op(20, 0, lat);
        checks++;
        if (lat !== 5) begin errors++; $display("FAIL b2b_latency: got %0d want 5", lat); end
        checks++;
        if (pid_output !== 18'sd20) begin
            errors++; $display("FAIL b2b_out: got %0d want 20", pid_output);
        end
    endtask

    initial begin
        test_reset();
        test_reset_mid_op();
        test_p_only();
        test_i_only();
        test_d_only();
        test_clamp();
        test_windup();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pid_seq.md
Name: pid_seq

Overview:
Parametrised, sequentially scheduled fixed-point PID controller. It is the next generation of the team's 18-bit pid block.
- Adds generic width and fraction bits, run-time gains, a start/busy/done handshake, output clamping and integrator clear.
- One shared signed multiplier is time-multiplexed over the P, I and D terms.
- Sits between the position-sensor sample path (yk) and the servo PWM/drive stage.

Parameters:
W, 18, data/gain width; signed two's complement
FRAC, 8, fractional bits of gains (1.0 = 2^FRAC)
OUT_MAX, 2^(W-1)-1, upper output clamp (signed W-bit)
OUT_MIN, -2^(W-1), lower output clamp (signed W-bit)

Ports:
sclk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
enable  in  1  start pulse; sampled only when busy=0
clear  in  1  synchronous: zero integrator and e_prev (honoured only when busy=0)
yk  in  W  measured value, signed
rk  in  W  reference, signed
kp  in  W  proportional gain, signed QW.FRAC
ki  in  W  integral gain, signed
kd  in  W  derivative gain, signed
pid_output  out  W  controller output, signed, registered
busy  out  1  high from the cycle after enable accepted until done
done  out  1  one-cycle pulse, pid_output valid/updated

Behaviour:
- Reset state: pid_output=0, busy=0, done=0, integ=0, e_prev=0, sat_hi=sat_lo=0, FSM=IDLE.
- Reset mid-operation: aborts the computation and returns to IDLE with the same values; no done pulse.
- FSM states: IDLE, ERR, MUL_P, MUL_I, MUL_D, SUM.
- IDLE:
  - enable=1 latches yk, rk, kp, ki, kd; busy<=1; goes to ERR.
  - clear=1 with enable=0 zeroes integ and e_prev.
  - clear and enable together: clear applies first, then the operation starts with integ=0, e_prev=0.
- ERR:
  - e = sat_W(rk - yk), computed at W+1 bits.
  - integ <= sat_W(integ + e).
  - d = sat_W(e - e_prev).
  - e_prev <= e.
- MUL_P / MUL_I / MUL_D: one per cycle, using the same multiplier.
  - pterm = kp*e, iterm = ki*integ, dterm = kd*d.
  - Each product is 2W bits, arithmetic-shifted right by FRAC (floor).
- SUM:
  - s = pterm + iterm + dterm at 2W+2 bits.
  - pid_output <= clamp(s, OUT_MIN, OUT_MAX).
  - sat_hi <= (s > OUT_MAX); sat_lo <= (s < OUT_MIN).
  - done <= 1 for exactly one cycle; busy <= 0; FSM -> IDLE.
- Latency: the enable edge is cycle 0; pid_output and done change at cycle 5 and are visible from cycle 5 to 6.
- A new enable is accepted in the cycle done is high (back-to-back throughput: 1 result per 6 cycles).
- enable while busy=1 is ignored; no queueing.
- pid_output holds its value between operations.

Optional Feature:
PID_ANTIWINDUP_EN
- Defined: in ERR, the integrator update is skipped (integ held) when (sat_hi and e>0) or (sat_lo and e<0). The flags come from the previous result.
- Undefined: integ always updates as sat_W(integ+e); sat_hi/sat_lo are still computed but unused.

Test Plan:
All scenarios use W=18, FRAC=8.
- Reset: hold rst for 10 cycles -> pid_output=0, busy=0, done=0; enable during rst is ignored.
- P only: kp=256, ki=kd=0, rk=1000, yk=400 -> done exactly 5 cycles after the enable edge, pid_output=600. Then rk=0, yk=300 -> -300.
- I only: ki=128, kp=kd=0, rk-yk=100 for three ops -> 50, 100, 150. Then clear pulse, same op -> 50.
- D only: kd=256, e sequence 100, 300, 300 -> 100, 200, 0. Enable pulsed while busy -> no extra done, result unchanged.
- Clamp: OUT_MAX=1000, OUT_MIN=-1000, kp=512, e=800 -> 1000; e=-800 -> -1000.
- Windup: OUT_MAX=1000, ki=256, kp=kd=0, e = 600, 600, 600, -300.
  - With PID_ANTIWINDUP_EN: 600, 1000, 1000, 900.
  - Without it: 600, 1000, 1000, 1000 (integ=1500).
